// File: rtl/hdp_reg_sequencer.sv
// SPI register sequencer: sweeps an init table out over SPI and serves host register accesses.
// Optional build macro HDP_SEQ_VERIFY_EN adds a read-back check after every init write.
module hdp_reg_sequencer #(
    parameter int TBL_LEN      = 16,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       init_start,
    output logic [7:0] tbl_index,
    input  logic [6:0] tbl_addr,
    input  logic [7:0] tbl_data,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       spi_start,
    input  logic       spi_busy,
    output logic [7:0] spi_tx_upper,
    output logic [7:0] spi_tx_lower,
    input  logic [7:0] spi_rx_lower,
    output logic       init_busy,
    output logic       init_done,
    output logic       error
);

    localparam int CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, CHECK, FAULT
    } state_t;

    state_t           state, next_state;
    logic             sync1, sbusy;
    logic [CNT_W-1:0] to_cnt;
    logic             is_init;
    logic             last_entry;
`ifdef HDP_SEQ_VERIFY_EN
    logic             rd_phase;
    logic [7:0]       rx_byte;
`endif

    assign last_entry = (tbl_index == 8'(TBL_LEN - 1));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable && init_start)    next_state = FETCH;
                else if (enable && host_req) next_state = ISSUE;
            end
            FETCH:   next_state = ISSUE;
            ISSUE:   next_state = WAIT_HI;
            WAIT_HI: begin
                if (sbusy)                                    next_state = WAIT_LO;
                else if (to_cnt == CNT_W'(BUSY_TIMEOUT - 1)) next_state = FAULT;
            end
            WAIT_LO: if (!sbusy) next_state = CHECK;
            CHECK: begin
                if (!is_init)                  next_state = IDLE;
`ifdef HDP_SEQ_VERIFY_EN
                else if (!rd_phase)            next_state = ISSUE;
                else if (rx_byte != spi_tx_lower) next_state = FAULT;
`endif
                else if (last_entry)           next_state = IDLE;
                else                           next_state = FETCH;
            end
            FAULT:   if (enable && init_start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Start is purely state-decoded so an asynchronous reset drops it at once.
    assign spi_start = (state == ISSUE) || (state == WAIT_HI);
    assign host_ack  = (state == CHECK) && !is_init;
    assign init_done = (state == CHECK) && is_init && (next_state == IDLE);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1        <= 1'b0;
            sbusy        <= 1'b0;
            to_cnt       <= '0;
            is_init      <= 1'b0;
            tbl_index    <= 8'h00;
            spi_tx_upper <= 8'h00;
            spi_tx_lower <= 8'h00;
            host_rdata   <= 8'h00;
            init_busy    <= 1'b0;
            error        <= 1'b0;
`ifdef HDP_SEQ_VERIFY_EN
            rd_phase     <= 1'b0;
            rx_byte      <= 8'h00;
`endif
        end else begin
            sync1 <= spi_busy;
            sbusy <= sync1;
            case (state)
                IDLE: begin
                    if (next_state == FETCH) begin
                        tbl_index <= 8'h00;
                        init_busy <= 1'b1;
                        is_init   <= 1'b1;
                    end else if (next_state == ISSUE) begin
                        is_init      <= 1'b0;
                        spi_tx_upper <= {host_rw, host_addr};
                        spi_tx_lower <= host_rw ? 8'h00 : host_wdata;
                    end
                end
                FETCH: begin
                    spi_tx_upper <= {1'b0, tbl_addr};
                    spi_tx_lower <= tbl_data;
`ifdef HDP_SEQ_VERIFY_EN
                    rd_phase     <= 1'b0;
`endif
                end
                ISSUE: to_cnt <= '0;
                WAIT_HI: begin
                    if (next_state == FAULT) begin
                        error     <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (next_state == CHECK) begin
`ifdef HDP_SEQ_VERIFY_EN
                        rx_byte <= spi_rx_lower;
`endif
                        if (!is_init) host_rdata <= spi_tx_upper[7] ? spi_rx_lower : 8'h00;
                    end
                end
                CHECK: begin
                    if (next_state == FETCH) begin
                        tbl_index <= tbl_index + 8'd1;
                    end else if (next_state == IDLE) begin
                        if (is_init) init_busy <= 1'b0;
                    end else if (next_state == FAULT) begin
                        error     <= 1'b1;
                        init_busy <= 1'b0;
                    end
`ifdef HDP_SEQ_VERIFY_EN
                    // Read-back reuses the written data byte as the compare reference.
                    else if (next_state == ISSUE) begin
                        rd_phase        <= 1'b1;
                        spi_tx_upper[7] <= 1'b1;
                    end
`endif
                end
                FAULT: begin
                    if (next_state == FETCH) begin
                        error     <= 1'b0;
                        tbl_index <= 8'h00;
                        init_busy <= 1'b1;
                        is_init   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hdp_reg_sequencer.md
HDP_REG_SEQUENCER -- requirements
Module: hdp_reg_sequencer

Interface
REQ-001 Parameter TBL_LEN, default 16: number of init-table entries; range 1..256.
REQ-002 Parameter BUSY_TIMEOUT, default 1023: sys_clk cycles allowed for synced busy to rise after start.
REQ-003 sys_clk  in  1  single system clock (50 MHz); all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  block enable; while low, no new transaction starts.
REQ-006 init_start  in  1  one-cycle pulse; starts an init-table sweep.
REQ-007 tbl_index  out  8  current init-table entry index.
REQ-008 tbl_addr / tbl_data  in  7 / 8  register address and data for tbl_index, valid combinationally.
REQ-009 host_req / host_rw / host_addr / host_wdata  in  1/1/7/8  host access request; rw=1 read, rw=0 write.
REQ-010 host_ack / host_rdata  out  1/8  one-cycle completion pulse; read data valid with ack.
REQ-011 spi_start  out  1  drives SPI start_transfer.
REQ-012 spi_busy  in  1  SPI busy flag, asynchronous to sys_clk.
REQ-013 spi_tx_upper / spi_tx_lower  out  8/8  command byte {rw, addr[6:0]} and data byte.
REQ-014 spi_rx_lower  in  8  SPI received lower byte.
REQ-015 init_busy / init_done / error  out  1/1/1  sweep in progress / sweep completed / fault latched.

Function
REQ-016 spi_busy SHALL pass through a 2-flop synchronizer; all decisions use synced busy (sbusy).
REQ-017 States: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, CHECK, FAULT.
REQ-018 IDLE: init_start with enable -> FETCH (tbl_index=0, init_busy=1); else host_req with enable -> ISSUE with host fields latched.
REQ-019 Arbitration: init sweep has priority; host_req seen during a sweep is held off until sweep ends; host_req SHALL be held high until host_ack.
REQ-020 FETCH latches tbl_addr/tbl_data into tx registers with rw=0, then -> ISSUE.
REQ-021 ISSUE asserts spi_start, tx bytes stable, -> WAIT_HI.
REQ-022 WAIT_HI holds spi_start high until sbusy=1, then deasserts spi_start -> WAIT_LO; if BUSY_TIMEOUT cycles elapse first -> FAULT.
REQ-023 WAIT_LO waits for sbusy=0, then samples spi_rx_lower -> CHECK; tx bytes SHALL not change from ISSUE through WAIT_LO.
REQ-024 CHECK, host access: host_ack=1 for one cycle, host_rdata=sampled byte for reads (0x00 for writes), -> IDLE.
REQ-025 CHECK, init access: if tbl_index=TBL_LEN-1, pulse init_done one cycle, clear init_busy, -> IDLE; else increment tbl_index -> FETCH.
REQ-026 FAULT: error=1, spi_start=0, init_busy=0; exit only on init_start (clears error, restarts sweep) or reset.
REQ-027 enable low mid-transaction SHALL NOT abort; current transaction completes, then block stays IDLE.
REQ-028 init_start while init_busy=1 SHALL be ignored.
REQ-029 Address field is 7 bits; bit 7 of spi_tx_upper is the rw bit only.

Reset
REQ-030 On reset: state IDLE, spi_start=0, tx bytes 0x00, tbl_index=0, host_ack=0, host_rdata=0x00, init_busy=0, init_done=0, error=0, synchronizer flops 0.
REQ-031 Reset mid-transaction SHALL drop spi_start immediately; SPI block is assumed reset by the same reset.

Configuration
REQ-032 Macro HDP_SEQ_VERIFY_EN: when defined, each init write is followed by a read of the same address (rw=1) via ISSUE/WAIT_HI/WAIT_LO; mismatch of spi_rx_lower vs written data -> FAULT; match proceeds per REQ-025.
REQ-033 Without HDP_SEQ_VERIFY_EN: no readback, one SPI transaction per table entry, no mismatch fault.

Verification
REQ-034 Reset, TBL_LEN=3 table {0x01:0xA5, 0x02:0x3C, 0x7F:0xFF}, init_start -> SPI sees 0x01A5, 0x023C, 0x7FFF in order; init_done pulses once; error=0.
REQ-035 Host read addr 0x10, SPI model returns 0x5A -> tx_upper=0x90, host_ack one cycle with host_rdata=0x5A.
REQ-036 host_req raised during sweep -> served only after init_done; exactly one host_ack.
REQ-037 SPI model never raises busy -> error=1 after 1023 cycles in WAIT_HI, spi_start=0; init_start clears error and restarts at index 0.
REQ-038 HDP_SEQ_VERIFY_EN defined, readback 0xA4 for write 0xA5 -> FAULT after first entry, tbl_index=0; with matching readback, sweep makes 6 SPI transactions.
REQ-039 Reset asserted during WAIT_LO -> all outputs at reset values next cycle; fresh init_start completes normally.
